// File: rtl/uart_threshold_regs.sv
// rtl/uart_threshold_regs.sv - UART-programmable threshold register bank with framed write/read commands
//
// Purpose: parses framed write/read commands from a UART byte engine, updates
// one threshold channel per good write frame and answers with ACK/NAK or
// readback data.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   rx_data/rx_valid  - received byte and its one-cycle valid pulse
//   tx_ready          - transmitter idle
//   tx_data/tx_start  - byte to transmit and its one-cycle request
//   th_flat           - all thresholds, channel k at [k*TH_W +: TH_W]
//   th_update(_ch)    - one-cycle write pulse and the channel written
//   err               - one-cycle protocol error pulse
//   busy              - state is not IDLE
module uart_threshold_regs #(
    parameter int              NUM_CH      = 8,
    parameter int              TH_W        = 16,
    parameter logic [TH_W-1:0] DEFAULT_TH  = '0,
    parameter int              TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic [NUM_CH*TH_W-1:0]   th_flat,
    output logic                     th_update,
    output logic [7:0]               th_update_ch,
    output logic                     err,
    output logic                     busy
);
    localparam int NB     = TH_W / 8;
    localparam int RESP_W = TH_W + 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CHAN, S_DATA, S_CSUM, S_EXEC, S_TX_LOAD, S_TX_WAIT
    } state_t;

    state_t            r_state;
    logic              r_is_wr;
    logic [7:0]        r_ch;
    logic [7:0]        r_csum;
    logic              r_csum_ok;
    logic [TH_W-1:0]   r_data;
    logic [2:0]        r_byte_cnt;
    logic [31:0]       r_to_cnt;
    logic [RESP_W-1:0] r_resp;      // queued response bytes, next byte at the top
    logic [2:0]        r_resp_cnt;  // bytes still to send, including the top one
    logic              r_tx_hold;   // the one-cycle pause after each tx_start
    logic [TH_W-1:0]   r_th [NUM_CH];
    logic              r_th_update;
    logic [7:0]        r_th_update_ch;
    logic              r_err;

    logic              w_ch_ok;
    logic              w_timeout;
    logic [TH_W-1:0]   w_rd_val;
    logic [7:0]        w_rd_xor;

    assign w_ch_ok   = ({24'd0, r_ch} < 32'(NUM_CH));
    assign w_timeout = (r_to_cnt == 32'(TIMEOUT_CYC - 1));

    // Channel lookup by compare rather than indexing, so an out-of-range
    // index can never alias onto a real channel.
    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == 8'(k)) w_rd_val = r_th[k];
        end
        w_rd_xor = '0;
        for (int b = 0; b < NB; b++) begin
            w_rd_xor = w_rd_xor ^ w_rd_val[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_is_wr        <= 1'b0;
            r_ch           <= '0;
            r_csum         <= '0;
            r_csum_ok      <= 1'b0;
            r_data         <= '0;
            r_byte_cnt     <= '0;
            r_to_cnt       <= '0;
            r_resp         <= '0;
            r_resp_cnt     <= '0;
            r_tx_hold      <= 1'b0;
            r_th_update    <= 1'b0;
            r_th_update_ch <= '0;
            r_err          <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_th[k] <= DEFAULT_TH;
        end else begin
            r_err       <= 1'b0;
            r_th_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_to_cnt <= '0;
                    if (rx_valid) begin
                        if (rx_data == 8'h57 || rx_data == 8'h52) begin
                            r_is_wr    <= (rx_data == 8'h57);
                            r_csum     <= rx_data;
                            r_byte_cnt <= '0;
                            r_data     <= '0;
                            r_state    <= S_CHAN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_CHAN, S_DATA, S_CSUM: begin
                    if (rx_valid) begin
                        r_to_cnt <= '0;
                        r_csum   <= r_csum ^ rx_data;
                        case (r_state)
                            S_CHAN: begin
                                r_ch    <= rx_data;
                                r_state <= r_is_wr ? S_DATA : S_CSUM;
                            end
                            S_DATA: begin
                                r_data     <= (r_data << 8) | TH_W'(rx_data);
                                r_byte_cnt <= r_byte_cnt + 3'd1;
                                if (r_byte_cnt == 3'(NB - 1)) r_state <= S_CSUM;
                            end
                            default: begin
                                r_csum_ok <= (rx_data == r_csum);
                                r_state   <= S_EXEC;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
                end
                S_EXEC: begin
                    if (rx_valid) r_err <= 1'b1;
                    if (r_csum_ok && w_ch_ok) begin
                        if (r_is_wr) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (r_ch == 8'(k)) r_th[k] <= r_data;
                            end
                            r_th_update    <= 1'b1;
                            r_th_update_ch <= r_ch;
                            r_resp         <= {8'h06, {(RESP_W-8){1'b0}}};
                            r_resp_cnt     <= 3'd1;
                        end else begin
                            r_resp     <= {w_rd_val, w_rd_xor};
                            r_resp_cnt <= 3'(NB + 1);
                        end
                    end else begin
                        r_resp     <= {8'h15, {(RESP_W-8){1'b0}}};
                        r_resp_cnt <= 3'd1;
                    end
                    r_state <= S_TX_LOAD;
                end
                S_TX_LOAD: begin
                    if (rx_valid) r_err <= 1'b1;
                    if (tx_ready) begin
                        r_tx_hold <= 1'b1;
                        r_state   <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (rx_valid) r_err <= 1'b1;
                    // The pause gives the transmitter a cycle to drop tx_ready.
                    if (r_tx_hold) begin
                        r_tx_hold <= 1'b0;
                    end else if (tx_ready) begin
                        if (r_resp_cnt > 3'd1) begin
                            r_resp     <= r_resp << 8;
                            r_resp_cnt <= r_resp_cnt - 3'd1;
                            r_state    <= S_TX_LOAD;
                        end else begin
                            r_resp_cnt <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // tx_start follows tx_ready in TX_LOAD so the first response byte can
    // start in the same cycle the written value appears.
    assign tx_start     = (r_state == S_TX_LOAD) && tx_ready;
    assign tx_data      = r_resp[RESP_W-1 -: 8];
    assign th_update    = r_th_update;
    assign th_update_ch = r_th_update_ch;
    assign err          = r_err;
    assign busy         = (r_state != S_IDLE);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_flat
            assign th_flat[g*TH_W +: TH_W] = r_th[g];
        end
    endgenerate
endmodule

// File: doc/uart_threshold_regs.md
Name: uart_threshold_regs

Overview:
Parametrised, UART-programmable threshold register bank; generalises the fixed eight-threshold controller to NUM_CH channels of TH_W bits each.
Sits between the uart byte engine (data_rx/ready_rx, data_tx/start_tx/ready_tx) and the temperature/lux comparison logic.
Parses framed write/read commands with checksum, updates one channel per frame, and answers over tx with ACK/NAK or readback data.
Adds behaviour the fixed controller lacks: runtime writes, readback, range and checksum checks, and an inter-byte timeout.

Parameters:
NUM_CH, 8, number of threshold channels (1..256)
TH_W, 16, threshold width in bits; multiple of 8, 8..32
DEFAULT_TH, 0, reset value loaded into every channel
TIMEOUT_CYC, 100000, idle clk cycles allowed between bytes of one frame

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx_data  in  8  received byte from uart
rx_valid  in  1  one-cycle pulse; rx_data valid
tx_ready  in  1  uart transmitter idle, can accept a byte
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit request
th_flat  out  NUM_CH*TH_W  all thresholds; channel k occupies bits [k*TH_W +: TH_W]
th_update  out  1  one-cycle pulse when a channel is written
th_update_ch  out  8  index of the channel written; valid with th_update
err  out  1  one-cycle pulse on protocol error
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - every channel = DEFAULT_TH; tx_data=0, tx_start=0, th_update=0, th_update_ch=0, err=0.
  - state=IDLE; checksum, byte counter and timeout counter cleared.
  - Reset mid-frame discards the frame; no partial write ever reaches th_flat.
- Frame format:
  - Write: 0x57, ch, TH_W/8 data bytes MSB first, csum.
  - Read: 0x52, ch, csum.
  - csum = XOR of all preceding bytes in the frame.
- States: IDLE, CHAN, DATA, CSUM, EXEC, TX_LOAD, TX_WAIT.
- IDLE:
  - rx_valid with 0x57 or 0x52: latch the command, set running xor = byte, go to CHAN.
  - rx_valid with any other byte: pulse err, stay in IDLE.
- CHAN: latch the channel index, xor it in.
  - Write: go to DATA.
  - Read: go to CSUM.
- DATA: shift in TH_W/8 bytes MSB first, xor each, then go to CSUM.
- CSUM: compare the received byte with the running xor, then go to EXEC.
- EXEC (one cycle):
  - Bad csum, or ch >= NUM_CH: NAK 0x15, no write.
  - Good write: channel updated at the end of EXEC; th_update=1 and th_update_ch=ch in the cycle the new value first appears on th_flat.
  - Response queue: write → 0x06 (ACK); read → TH_W/8 data bytes MSB first, then the xor of those bytes.
- TX_LOAD: when tx_ready=1, drive tx_data and pulse tx_start for one cycle, then go to TX_WAIT.
- TX_WAIT:
  - Wait one cycle, then wait for tx_ready=1.
  - More bytes queued → TX_LOAD; otherwise → IDLE.
- Latency: csum byte accepted in cycle N → th_flat/th_update visible in cycle N+2 → earliest tx_start in cycle N+2.
- Timeout:
  - In CHAN, DATA or CSUM, the counter increments each cycle without rx_valid and resets on each rx_valid.
  - Reaching TIMEOUT_CYC: pulse err, drop the frame, go to IDLE.
- rx_valid during EXEC, TX_LOAD or TX_WAIT: byte dropped, err pulsed, state unaffected.
- Back-to-back frames: a new frame is accepted starting with the first rx_valid after returning to IDLE.
- Channel index width is 8; values >= NUM_CH take the NAK path and are never aliased or wrapped.

Test Plan:
1. Write 57 02 12 34 73 (NUM_CH=8, TH_W=16) → ch2=0x1234 two cycles after the csum byte; th_update pulses with th_update_ch=2; tx sends 0x06; all other channels remain 0.
2. After test 1, read 52 02 50 → tx sends 12, 34, 26 in order; no th_update.
3. Bad checksum: 57 02 AB CD 00 → tx sends 0x15; ch2 remains 0x1234; no th_update.
4. Out-of-range channel: 57 09 00 01 5F → tx sends 0x15; no channel changes.
5. Timeout: send 57 02, then silence for TIMEOUT_CYC cycles → single err pulse, busy falls; a following valid write frame completes with ACK.
6. Reset and stray bytes:
   - Assert rst after 57 02 12 → all channels = DEFAULT_TH, tx_start=0.
   - Send a stray byte 0x41 in IDLE → err pulse, no tx.
   - Send a byte during an ACK transmit → err pulse; the ACK is still transmitted.
